// File: rtl/wind_profile_loader_pkg.sv
// Shared constants and types for the wind-speed profile loader.
// Default widths and depth match the wind-turbine reader: an 8-bit bank address, 200 samples
// per bank, single-precision samples and a 1024-cycle idle timeout.
// Also holds the loader state encoding.
package wind_profile_loader_pkg;

  localparam int unsigned WindAddrWidth = 8;
  localparam int unsigned WindDepth     = 200;
  localparam int unsigned WindDataWidth = 32;
  localparam int unsigned WindTimeout   = 1024;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad1 = 2'd1,
    StLoad2 = 2'd2,
    StFin   = 2'd3
  } load_state_e;

endpackage

// File: rtl/wind_profile_loader_if.sv
// Valid/ready sample stream from the host/config path into the profile loader.
//   s_valid : sample valid (source -> loader)
//   s_data  : sample, DATA_WIDTH bits, not interpreted (source -> loader)
//   s_last  : final sample of the whole profile (source -> loader)
//   s_ready : loader can accept a sample (loader -> source)
// Modports: master = sample source, slave = loader.
interface wind_profile_loader_if
  import wind_profile_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = WindDataWidth
) ();

  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  s_ready;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/wind_loader_timeout.sv
// Idle-cycle counter for the profile loader.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force the count to zero (takes priority over en)
//   en       : count one idle cycle
//   expired  : this idle cycle brings the count to TIMEOUT-1 (combinational)
module wind_loader_timeout
  import wind_profile_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT = WindTimeout
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Flag the cycle whose increment lands on TIMEOUT-1, so the abort is taken at that same edge.
  assign expired = en & ~clr & (cnt_q == CntW'(TIMEOUT - 2));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wind_profile_loader.sv
// Writer side of the wind-speed profile tables. Streams 2*DEPTH samples into bank 1
// (first DEPTH) then bank 2 (next DEPTH), one sample per cycle.
//   clk, rst   : clock, synchronous active-high reset
//   sta        : start pulse, honoured only when idle
//   s          : sample stream (slave side)
//   waddr      : bank write address (registered)
//   wdata      : bank write data (registered)
//   we1, we2   : bank 1 / bank 2 write enables (registered, never both high)
//   busy       : load in progress
//   done       : one-cycle pulse on successful completion
//   err        : sticky error (short profile or timeout), cleared by an accepted sta or rst
module wind_profile_loader
  import wind_profile_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = WindAddrWidth,
  parameter int unsigned DEPTH      = WindDepth,
  parameter int unsigned DATA_WIDTH = WindDataWidth,
  parameter int unsigned TIMEOUT    = WindTimeout
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sta,
  wind_profile_loader_if.slave  s,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  we1,
  output logic                  we2,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  load_state_e           state_d, state_q;
  logic [ADDR_WIDTH-1:0] cnt_d, cnt_q;
  logic                  err_d, err_q;
  logic [ADDR_WIDTH-1:0] waddr_d, waddr_q;
  logic [DATA_WIDTH-1:0] wdata_d, wdata_q;
  logic                  we1_d, we1_q;
  logic                  we2_d, we2_q;

  logic ready;
  logic loading;
  logic accept;
  logic last_word;
  logic tmo_clr;
  logic tmo_en;
  logic tmo_expired;

  assign loading   = (state_q == StLoad1) || (state_q == StLoad2);
  assign accept    = s.s_valid & ready;
  // Wrap at DEPTH-1, not at the natural 2^ADDR_WIDTH rollover.
  assign last_word = (cnt_q == ADDR_WIDTH'(DEPTH - 1));

  assign tmo_clr = ~loading | accept;
  assign tmo_en  = loading & ~accept;

  wind_loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  // Next state, word counter and error flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (sta) begin
          state_d = StLoad1;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      StLoad1, StLoad2: begin
        if (accept) begin
          cnt_d = last_word ? '0 : cnt_q + ADDR_WIDTH'(1);
          if (s.s_last && !((state_q == StLoad2) && last_word)) begin
            // Short profile: the beat is still written, then abort.
            err_d   = 1'b1;
            state_d = StIdle;
          end else if (last_word) begin
            state_d = (state_q == StLoad1) ? StLoad2 : StFin;
          end
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (state_q)
      StLoad1, StLoad2: begin
        ready = 1'b1;
        busy  = 1'b1;
      end
      StFin: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

  // Bank write port, one cycle behind the accepted beat; address/data hold between writes.
  always_comb begin
    we1_d   = accept & (state_q == StLoad1);
    we2_d   = accept & (state_q == StLoad2);
    waddr_d = accept ? cnt_q : waddr_q;
    wdata_d = accept ? s.s_data : wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      we1_q   <= 1'b0;
      we2_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we1_q   <= we1_d;
      we2_q   <= we2_d;
    end
  end

  assign s.s_ready = ready;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign we1       = we1_q;
  assign we2       = we2_q;
  assign err       = err_q;

endmodule

// File: tb/tb_wind_profile_loader.sv
// Self-checking bench for wind_profile_loader with DEPTH=4, ADDR_WIDTH=3, TIMEOUT=16.
// Expected writes come from the list of beats sent: beat i lands in bank (i < DEPTH ? 1 : 2)
// at address i % DEPTH with the beat's data.
module tb_wind_profile_loader;

  localparam int unsigned AW = 3;
  localparam int unsigned DP = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          sta;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          we1, we2, busy, done, err;

  wind_profile_loader_if #(.DATA_WIDTH(DW)) sif ();

  wind_profile_loader #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DP),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sta   (sta),
    .s     (sif),
    .waddr (waddr),
    .wdata (wdata),
    .we1   (we1),
    .we2   (we2),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          b2;
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          overlap_cnt = 0;
  wr_t         got[$];
  logic [31:0] sent[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record every bank write and every done pulse.
  always @(negedge clk) begin
    if (we1 || we2) got.push_back('{b2: we2, addr: int'(waddr), data: wdata, cyc: cyc});
    if (we1 && we2) overlap_cnt <= overlap_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of run, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    sta = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_last = 1'b0;
    sif.s_data = '0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, sif.s_ready, 0);
    chk({tag, "_we1"}, we1, 0);
    chk({tag, "_we2"}, we2, 0);
    chk({tag, "_waddr"}, waddr, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Pulse sta for one cycle; t0 is the cycle in which sta is sampled.
  task automatic pulse_sta(output int t0);
    sta = 1'b1;
    t0 = cyc;
    step(1);
    sta = 1'b0;
  endtask

  // Offer one beat after 'gap' idle cycles and wait until it is accepted.
  task automatic push(input logic [31:0] d, input bit l, input int gap, input bit st,
                      output int acc);
    bit ok = 1'b0;
    step(gap);
    sif.s_valid = 1'b1;
    sif.s_data = d;
    sif.s_last = l;
    sta = st;
    sent.push_back(d);
    acc = -1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (sif.s_ready) begin
        acc = cyc;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("push_accept", sif.s_ready, 1);
    @(posedge clk);
    #1;
    sif.s_valid = 1'b0;
    sif.s_last = 1'b0;
    sta = 1'b0;
  endtask

  // Compare recorded writes from index 'base' against the beats sent.
  task automatic check_writes(input string tag, input int base);
    int n = sent.size();
    chk({tag, "_count"}, got.size() - base, n);
    for (int i = 0; i < n && base + i < got.size(); i++) begin
      chk({tag, "_bank2"}, got[base + i].b2, (i >= int'(DP)));
      chk({tag, "_addr"}, got[base + i].addr, i % int'(DP));
      chk({tag, "_data"}, got[base + i].data, sent[i]);
    end
  endtask

  int base, dbase, t0, acc;

  initial begin
    apply_reset();
    step(1);
    @(negedge clk);
    check_reset_outputs("reset");
    step(1);

    // Full back-to-back load.
    sent.delete();
    base = got.size();
    dbase = done_cnt;
    pulse_sta(t0);
    for (int i = 0; i < 8; i++) push(32'h3F80_0000 + i, (i == 7), 0, 1'b0, acc);
    step(3);
    @(negedge clk);
    check_writes("full", base);
    for (int i = 0; i < 8 && base + i < got.size(); i++)
      chk("full_cycle", got[base + i].cyc - t0, i + 2);
    chk("full_done", done_cnt - dbase, 1);
    chk("full_err", err, 0);
    chk("full_busy", busy, 0);
    step(1);

    // Random gaps, with and without the optional final s_last.
    for (int r = 0; r < 2; r++) begin
      sent.delete();
      base = got.size();
      dbase = done_cnt;
      pulse_sta(t0);
      for (int i = 0; i < 8; i++)
        push($urandom, (i == 7) && (r == 0), $urandom_range(0, 5), 1'b0, acc);
      step(3);
      @(negedge clk);
      check_writes("gaps", base);
      chk("gaps_done", done_cnt - dbase, 1);
      chk("gaps_err", err, 0);
      step(1);
    end

    // Early s_last on beat 5.
    sent.delete();
    base = got.size();
    dbase = done_cnt;
    pulse_sta(t0);
    for (int i = 0; i < 6; i++) push($urandom, (i == 5), $urandom_range(0, 2), 1'b0, acc);
    @(negedge clk);
    chk("short_err", err, 1);
    chk("short_busy", busy, 0);
    chk("short_ready", sif.s_ready, 0);
    step(4);
    @(negedge clk);
    check_writes("short", base);
    chk("short_done", done_cnt - dbase, 0);
    step(1);
    pulse_sta(t0);
    @(negedge clk);
    chk("short_err_cleared", err, 0);
    chk("short_restart_busy", busy, 1);
    step(1);
    apply_reset();

    // Stall in LOAD1 after two beats.
    sent.delete();
    base = got.size();
    pulse_sta(t0);
    push($urandom, 1'b0, 0, 1'b0, acc);
    push($urandom, 1'b0, 0, 1'b0, acc);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (err) break;
    end
    chk("tmo_delay", cyc - acc, TO);
    step(5);
    @(negedge clk);
    check_writes("tmo", base);
    chk("tmo_busy", busy, 0);
    chk("tmo_err", err, 1);
    step(1);

    // Reset during LOAD2.
    sent.delete();
    base = got.size();
    pulse_sta(t0);
    for (int i = 0; i < 5; i++) push($urandom, 1'b0, 0, 1'b0, acc);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    step(3);
    @(negedge clk);
    check_writes("midrst", base);
    step(1);

    // Restart after reset; sta pulsed during LOAD1 and in the FIN cycle.
    sent.delete();
    base = got.size();
    dbase = done_cnt;
    pulse_sta(t0);
    for (int i = 0; i < 8; i++) push($urandom, (i == 7), 0, (i == 2), acc);
    sta = 1'b1;
    @(negedge clk);
    chk("fin_done", done, 1);
    step(1);
    sta = 1'b0;
    step(3);
    @(negedge clk);
    chk("fin_busy", busy, 0);
    chk("fin_ready", sif.s_ready, 0);
    chk("fin_done_cnt", done_cnt - dbase, 1);
    check_writes("restart", base);
    chk("we_overlap", overlap_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
